// File: rtl/asic_dpram_pkg.sv
// Shared types and constants for the dual-port RAM model.
// The INIT/READY state type and the all-zero word used by the clear sweep.
package asic_dpram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int MaxDataWidth = 1024;
  localparam logic [MaxDataWidth-1:0] ZERO_WORD = '0;

  function automatic logic addr_in_range(input int addr, input int depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/asic_dpram_init.sv
// Clear-sweep address counter: steps 0..DataDepth-1 while run is high.
// sweep_last flags the final address so the parent can leave INIT next edge.
module asic_dpram_init #(
  parameter int DataDepth   = 4,
  parameter int RAMAddWidth = 2
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   run,
  output logic [RAMAddWidth-1:0] sweep_addr,
  output logic                   sweep_last
);

  localparam logic [RAMAddWidth-1:0] LastAddr = RAMAddWidth'(DataDepth - 1);

  logic [RAMAddWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (run && !sweep_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sweep_addr = cnt_q;
  assign sweep_last = (cnt_q == LastAddr);

endmodule

// File: rtl/asic_dpram.sv
// Single-clock true dual-port RAM model with read-first ports, a zeroing sweep
// after reset, port-A-wins write arbitration and a same-address collision pulse.
module asic_dpram
  import asic_dpram_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int DataDepth   = 4,
  parameter int RAMAddWidth = 2
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   ena,
  input  logic                   enb,
  input  logic                   wea,
  input  logic                   web,
  input  logic [RAMAddWidth-1:0] addra,
  input  logic [RAMAddWidth-1:0] addrb,
  input  logic [DataWidth-1:0]   dina,
  input  logic [DataWidth-1:0]   dinb,
  output logic [DataWidth-1:0]   douta,
  output logic [DataWidth-1:0]   doutb,
  output logic                   init_done,
  output logic                   collision
);

  localparam logic [DataWidth-1:0] Zero = ZERO_WORD[DataWidth-1:0];

  // Deliberately not reset: only the INIT sweep clears the array.
  logic [DataWidth-1:0] mem [DataDepth];

  state_e               state_q, state_d;
  logic [DataWidth-1:0] douta_q, douta_d;
  logic [DataWidth-1:0] doutb_q, doutb_d;
  logic                 collision_q, collision_d;

  logic                   ready;
  logic                   a_ok, b_ok, same_addr;
  logic                   we_a, we_b;
  logic [DataWidth-1:0]   rd_a, rd_b;
  logic [RAMAddWidth-1:0] sweep_addr;
  logic                   sweep_last;

  asic_dpram_init #(
    .DataDepth   (DataDepth),
    .RAMAddWidth (RAMAddWidth)
  ) u_init (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .run        (state_q == ST_INIT),
    .sweep_addr (sweep_addr),
    .sweep_last (sweep_last)
  );

  always_comb begin
    ready     = (state_q == ST_READY);
    a_ok      = addr_in_range(32'(addra), DataDepth);
    b_ok      = addr_in_range(32'(addrb), DataDepth);
    same_addr = (addra == addrb);
    rd_a      = a_ok ? mem[addra] : Zero;
    rd_b      = b_ok ? mem[addrb] : Zero;
    we_a      = ready && ena && wea && a_ok;
    // Port B yields when both ports write the same word.
    we_b      = ready && enb && web && b_ok && !(we_a && same_addr);

    state_d = state_q;
    if (state_q == ST_INIT && sweep_last) begin
      state_d = ST_READY;
    end

    douta_d = douta_q;
    doutb_d = doutb_q;
    if (!ready) begin
      douta_d = Zero;
      doutb_d = Zero;
    end else begin
      if (ena) douta_d = rd_a;
      if (enb) doutb_d = rd_b;
    end

    collision_d = ready && ena && enb && a_ok && b_ok && same_addr && (wea || web);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= ST_INIT;
      douta_q     <= '0;
      doutb_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      douta_q     <= douta_d;
      doutb_q     <= doutb_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[sweep_addr] <= Zero;
    end else begin
      if (we_b) mem[addrb] <= dinb;
      if (we_a) mem[addra] <= dina;
    end
  end

  assign douta     = douta_q;
  assign doutb     = doutb_q;
  assign init_done = ready;
  assign collision = collision_q;

endmodule

// File: tb/tb_asic_dpram.sv
// Directed bench for asic_dpram: a default-size instance plus a DataDepth=3
// instance sharing the same stimulus to exercise out-of-range addresses.
module tb_asic_dpram;

  logic        clk;
  logic        aclr_n;
  logic        ena, enb, wea, web;
  logic [1:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb, d3_douta, d3_doutb;
  logic        init_done, collision, d3_init_done, d3_collision;

  int n_cmp;
  int n_err;

  asic_dpram dut (
    .clk(clk), .aclr_n(aclr_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta), .doutb(doutb), .init_done(init_done), .collision(collision)
  );

  asic_dpram #(.DataWidth(32), .DataDepth(3), .RAMAddWidth(2)) dut3 (
    .clk(clk), .aclr_n(aclr_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(d3_douta), .doutb(d3_doutb), .init_done(d3_init_done), .collision(d3_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
    addra = 2'd0; addrb = 2'd0; dina = '0; dinb = '0;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    ena = 1'b1; wea = 1'b1; addra = 2'd0; dina = 32'hBAD0BAD0;
    enb = 1'b1; web = 1'b1; addrb = 2'd1; dinb = 32'hBAD1BAD1;
    repeat (2) step();
    n_cmp++; if (douta !== 32'h0) begin n_err++; $display("FAIL rst_douta: got %h want 0", douta); end
    n_cmp++; if (doutb !== 32'h0) begin n_err++; $display("FAIL rst_doutb: got %h want 0", doutb); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL rst_collision: got %b want 0", collision); end
    aclr_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++; if (init_done !== (c == 4)) begin n_err++; $display("FAIL init_done_c%0d: got %b want %b", c, init_done, (c == 4)); end
      n_cmp++; if (d3_init_done !== (c >= 3)) begin n_err++; $display("FAIL d3_init_done_c%0d: got %b want %b", c, d3_init_done, (c >= 3)); end
      n_cmp++; if (douta !== 32'h0 || doutb !== 32'h0) begin n_err++; $display("FAIL init_dout_c%0d: got %h/%h want 0/0", c, douta, doutb); end
      if (c == 2) idle();
    end
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; addra = 2'(i); enb = 1'b1; addrb = 2'(3 - i);
      step();
      n_cmp++; if (douta !== 32'h0 || doutb !== 32'h0) begin n_err++; $display("FAIL clear_read_%0d: got %h/%h want 0/0", i, douta, doutb); end
      n_cmp++; if (d3_douta !== 32'h0 || d3_doutb !== 32'h0) begin n_err++; $display("FAIL d3_clear_read_%0d: got %h/%h want 0/0", i, d3_douta, d3_doutb); end
    end
    idle();
  endtask

  task automatic test_write_read();
    ena = 1'b1; wea = 1'b1; addra = 2'd1; dina = 32'hDEADBEEF;
    step();
    n_cmp++; if (douta !== 32'h0) begin n_err++; $display("FAIL wr_read_first: got %h want 0", douta); end
    idle();
    enb = 1'b1; addrb = 2'd1;
    step();
    n_cmp++; if (doutb !== 32'hDEADBEEF) begin n_err++; $display("FAIL b_read_addr1: got %h want deadbeef", doutb); end
    n_cmp++; if (douta !== 32'h0) begin n_err++; $display("FAIL a_hold: got %h want 0", douta); end
    n_cmp++; if (d3_doutb !== 32'hDEADBEEF) begin n_err++; $display("FAIL d3_b_read_addr1: got %h want deadbeef", d3_doutb); end
    idle();
  endtask

  task automatic test_ww_collision();
    ena = 1'b1; wea = 1'b1; addra = 2'd2; dina = 32'h11;
    enb = 1'b1; web = 1'b1; addrb = 2'd2; dinb = 32'h22;
    step();
    n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL ww_collision: got %b want 1", collision); end
    n_cmp++; if (douta !== 32'h0 || doutb !== 32'h0) begin n_err++; $display("FAIL ww_old_data: got %h/%h want 0/0", douta, doutb); end
    idle();
    step();
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL ww_pulse_end: got %b want 0", collision); end
    ena = 1'b1; addra = 2'd2; enb = 1'b1; addrb = 2'd2;
    step();
    n_cmp++; if (douta !== 32'h11 || doutb !== 32'h11) begin n_err++; $display("FAIL ww_a_wins: got %h/%h want 11/11", douta, doutb); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL rr_no_collision: got %b want 0", collision); end
    idle();
  endtask

  task automatic test_wr_collision();
    ena = 1'b1; wea = 1'b1; addra = 2'd3; dina = 32'h55;
    step();
    ena = 1'b1; wea = 1'b1; addra = 2'd3; dina = 32'h66;
    enb = 1'b1; web = 1'b0; addrb = 2'd3;
    step();
    n_cmp++; if (doutb !== 32'h55) begin n_err++; $display("FAIL wr_b_old: got %h want 55", doutb); end
    n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL wr_collision: got %b want 1", collision); end
    n_cmp++; if (d3_collision !== 1'b0 || d3_doutb !== 32'h0) begin n_err++; $display("FAIL d3_oob_wr: got coll=%b dout=%h want 0/0", d3_collision, d3_doutb); end
    idle();
    enb = 1'b1; addrb = 2'd3;
    step();
    n_cmp++; if (doutb !== 32'h66) begin n_err++; $display("FAIL wr_new_data: got %h want 66", doutb); end
    n_cmp++; if (douta !== 32'h55) begin n_err++; $display("FAIL a_hold_55: got %h want 55", douta); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL wr_pulse_end: got %b want 0", collision); end
    idle();
    enb = 1'b1; web = 1'b1; addrb = 2'd0; dinb = 32'hA5;
    ena = 1'b1; addra = 2'd0;
    step();
    n_cmp++; if (douta !== 32'h0 || collision !== 1'b1) begin n_err++; $display("FAIL bw_ar: got dout=%h coll=%b want 0/1", douta, collision); end
    idle();
    ena = 1'b1; addra = 2'd0;
    step();
    n_cmp++; if (douta !== 32'hA5) begin n_err++; $display("FAIL bw_readback: got %h want a5", douta); end
    idle();
  endtask

  task automatic test_out_of_range();
    ena = 1'b1; wea = 1'b1; addra = 2'd3; dina = 32'h77;
    enb = 1'b1; addrb = 2'd3;
    step();
    n_cmp++; if (d3_collision !== 1'b0) begin n_err++; $display("FAIL oob_no_collision: got %b want 0", d3_collision); end
    n_cmp++; if (d3_douta !== 32'h0 || d3_doutb !== 32'h0) begin n_err++; $display("FAIL oob_read: got %h/%h want 0/0", d3_douta, d3_doutb); end
    n_cmp++; if (doutb !== 32'h66 || collision !== 1'b1) begin n_err++; $display("FAIL inrange_wr: got dout=%h coll=%b want 66/1", doutb, collision); end
    idle();
    ena = 1'b1; addra = 2'd3;
    step();
    n_cmp++; if (d3_douta !== 32'h0) begin n_err++; $display("FAIL oob_readback: got %h want 0", d3_douta); end
    n_cmp++; if (d3_collision !== 1'b0) begin n_err++; $display("FAIL oob_coll_low: got %b want 0", d3_collision); end
    n_cmp++; if (douta !== 32'h77) begin n_err++; $display("FAIL inrange_readback: got %h want 77", douta); end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 2; i++) begin
      ena = 1'b1; wea = 1'b1; addra = 2'(i); dina = 32'h1000 + 32'(i);
      enb = 1'b1; addrb = 2'(i);
      step();
    end
    #2;
    aclr_n = 1'b0;
    #1;
    n_cmp++; if (douta !== 32'h0 || doutb !== 32'h0) begin n_err++; $display("FAIL midrst_dout: got %h/%h want 0/0", douta, doutb); end
    n_cmp++; if (init_done !== 1'b0 || d3_init_done !== 1'b0) begin n_err++; $display("FAIL midrst_init_done: got %b/%b want 0/0", init_done, d3_init_done); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL midrst_collision: got %b want 0", collision); end
    @(posedge clk);
    #1;
    idle();
    step();
    aclr_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL midrst_sweep_c3: got %b want 0", init_done); end
    step();
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL midrst_sweep_c4: got %b want 1", init_done); end
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; addra = 2'(i); enb = 1'b1; addrb = 2'(3 - i);
      step();
      n_cmp++; if (douta !== 32'h0 || doutb !== 32'h0) begin n_err++; $display("FAIL resweep_read_%0d: got %h/%h want 0/0", i, douta, doutb); end
      n_cmp++; if (d3_douta !== 32'h0 || d3_doutb !== 32'h0) begin n_err++; $display("FAIL d3_resweep_read_%0d: got %h/%h want 0/0", i, d3_douta, d3_doutb); end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    test_reset();
    test_write_read();
    test_ww_collision();
    test_wr_collision();
    test_out_of_range();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/asic_dpram.md
ASIC_DPRAM -- requirements
Module: asic_dpram

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DataDepth, default 4, number of stored words (1 to 2^RAMAddWidth).
REQ-003 The block SHALL have parameter RAMAddWidth, default 2, address width in bits.
REQ-004 The block SHALL have port clk, input, 1, the single clock for both ports.
REQ-005 The block SHALL have port aclr_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports ena / enb, input, 1 each, port A / B enable, active high.
REQ-007 The block SHALL have ports wea / web, input, 1 each, port A / B write, qualified by ena / enb.
REQ-008 The block SHALL have ports addra / addrb, input, RAMAddWidth each, port A / B address.
REQ-009 The block SHALL have ports dina / dinb, input, DataWidth each, port A / B write data.
REQ-010 The block SHALL have ports douta / doutb, output, DataWidth each, port A / B registered read data.
REQ-011 The block SHALL have port init_done, output, 1, high once the clear sweep has completed.
REQ-012 The block SHALL have port collision, output, 1, one-cycle pulse on a same-address port conflict.

Function
REQ-013 The block SHALL implement the states INIT and READY; it enters INIT on reset and moves to READY in the cycle after address DataDepth-1 is cleared.
REQ-014 In INIT, the block SHALL write zero to one address per cycle, from 0 to DataDepth-1 ascending, so INIT lasts exactly DataDepth cycles after aclr_n deasserts.
REQ-015 In INIT, the block SHALL ignore ena/enb/wea/web, SHALL hold douta/doutb at 0, and SHALL hold init_done at 0.
REQ-016 In READY, init_done SHALL be 1, and it SHALL stay 1 until the next reset.
REQ-017 In READY, when ena=1 and wea=0, douta SHALL present mem[addra] on the next rising clk edge (latency 1); port B SHALL behave the same on its own signals.
REQ-018 In READY, when ena=1 and wea=1, mem[addra] SHALL take dina at the clk edge, and douta SHALL update to the old contents (read-first); port B the same.
REQ-019 When a port's enable is 0, that port's output SHALL hold its previous value.
REQ-020 When both ports write the same address in one cycle, port A data SHALL be stored, and collision SHALL pulse for one cycle.
REQ-021 When one port writes and the other reads the same address in one cycle, the reading port SHALL return the old contents, and collision SHALL pulse for one cycle.
REQ-022 When both ports read the same address in one cycle, both SHALL return the same data, and collision SHALL NOT pulse.
REQ-023 For any address >= DataDepth, writes SHALL be discarded and reads SHALL return 0; such accesses SHALL NOT pulse collision.

Reset
REQ-024 Asserting aclr_n=0 at any time SHALL immediately force douta=0, doutb=0, init_done=0, collision=0, the sweep counter to 0, and the state to INIT.
REQ-025 A reset during INIT or READY SHALL abort any access in progress and restart a full clear sweep once aclr_n deasserts.
REQ-026 The memory array itself SHALL NOT be reset asynchronously; it SHALL be cleared only by the INIT sweep.

Structure
REQ-027 The state enum (INIT, READY) and the zero-word constant SHALL live in the shared package asic_dpram_pkg.
REQ-028 The clear-sweep counter and its terminal-count detect SHALL be a single sub-module, asic_dpram_init.
REQ-029 The memory array SHALL be a plain register array with no vendor primitive, so the model can stand in for the ASIC RAM macro in simulation.

Verification
REQ-030 Deassert reset with DataDepth=4, then read all addresses -> init_done rises 4 cycles after deassert, and all reads return 0.
REQ-031 A writes 0xDEADBEEF to addr 1, then B reads addr 1 next cycle -> doutb=0xDEADBEEF one cycle later.
REQ-032 A writes 0x11 and B writes 0x22 to addr 2 in the same cycle -> collision pulses once, and a later read of addr 2 returns 0x11.
REQ-033 mem[3]=0x55; A writes 0x66 to addr 3 while B reads addr 3 -> doutb=0x55, collision pulses, and the next read returns 0x66.
REQ-034 With DataDepth=3, write 0x77 to addr 3 and read it back -> read returns 0, and collision stays low.
REQ-035 Assert reset mid-write burst -> outputs go to 0 at once, init_done=0, and every address reads 0 after the new sweep.
